// File: rtl/fcb1_cu.sv
// FCB1 control unit: streams the input buffer and weight column through
// the MAC after one start pulse, then hands the result to the next stage.
module fcb1_cu #(
  parameter int IFM_DEPTH    = 32,
  parameter int ADDRESS_SIZE = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_from_previous,
  output logic                    end_to_previous,
  input  logic                    end_from_next,
  output logic                    start_to_next,
  output logic [ADDRESS_SIZE-1:0] read_address,
  output logic                    ifm_enable_read,
  output logic                    wm_enable_read,
  output logic                    accumulate_enable,
  output logic                    bias_sel,
  output logic                    fc_output_ready,
  output logic                    enable_write_next
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [ADDRESS_SIZE-1:0] LAST =
    ADDRESS_SIZE'(IFM_DEPTH - 1);

  state_t                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] cnt_q, cnt_d;
  logic [1:0]              drain_q, drain_d;
  logic                    rd_en, first_read, last_read;
  logic                    acc_q, bias_q;
  logic                    last_d1_q, fcr_q, ewn_q, stn_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    rd_en      = 1'b0;
    first_read = 1'b0;
    last_read  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        drain_d = '0;
        if (start_from_previous) state_d = READ;
      end
      READ: begin
        rd_en      = 1'b1;
        first_read = (cnt_q == '0);
        if (cnt_q == LAST) begin
          last_read = 1'b1;
          cnt_d     = '0;
          state_d   = DRAIN;
        end else begin
          cnt_d = cnt_q + ADDRESS_SIZE'(1);
        end
      end
      DRAIN: begin
        // three cycles: memory latency, MAC, then the write strobe
        if (drain_q == 2'd2) begin
          drain_d = '0;
          state_d = HOLD;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      HOLD: begin
        if (end_from_next) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drain_q   <= '0;
      acc_q     <= 1'b0;
      bias_q    <= 1'b0;
      last_d1_q <= 1'b0;
      fcr_q     <= 1'b0;
      ewn_q     <= 1'b0;
      stn_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      acc_q     <= rd_en;
      bias_q    <= first_read;
      last_d1_q <= last_read;
      fcr_q     <= last_d1_q;
      ewn_q     <= fcr_q;
      stn_q     <= ewn_q;
    end
  end

  assign end_to_previous   = (state_q == IDLE);
  assign read_address      = cnt_q;
  assign ifm_enable_read   = rd_en;
  assign wm_enable_read    = rd_en;
  assign accumulate_enable = acc_q;
  assign bias_sel          = bias_q;
  assign fc_output_ready   = fcr_q;
  assign enable_write_next = ewn_q;
  assign start_to_next     = stn_q;

endmodule

// File: tb/tb_fcb1_cu.sv
// Bench for fcb1_cu: expected output vectors per cycle are queued from the
// documented timeline and compared against three depth variants.
module tb_fcb1_cu;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic efn;

  always #5 clk = ~clk;

  logic [1:0] a0;
  logic [0:0] a1;
  logic [2:0] a2;
  logic [7:0] etp, stn, ifm, wm, acc, bias, fcr, ewn;

  fcb1_cu #(.IFM_DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset),
    .start_from_previous(start), .end_to_previous(etp[0]),
    .end_from_next(efn), .start_to_next(stn[0]),
    .read_address(a0), .ifm_enable_read(ifm[0]),
    .wm_enable_read(wm[0]), .accumulate_enable(acc[0]),
    .bias_sel(bias[0]), .fc_output_ready(fcr[0]),
    .enable_write_next(ewn[0])
  );

  fcb1_cu #(.IFM_DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset),
    .start_from_previous(start), .end_to_previous(etp[1]),
    .end_from_next(efn), .start_to_next(stn[1]),
    .read_address(a1), .ifm_enable_read(ifm[1]),
    .wm_enable_read(wm[1]), .accumulate_enable(acc[1]),
    .bias_sel(bias[1]), .fc_output_ready(fcr[1]),
    .enable_write_next(ewn[1])
  );

  fcb1_cu #(.IFM_DEPTH(5)) u_d5 (
    .clk(clk), .reset(reset),
    .start_from_previous(start), .end_to_previous(etp[2]),
    .end_from_next(efn), .start_to_next(stn[2]),
    .read_address(a2), .ifm_enable_read(ifm[2]),
    .wm_enable_read(wm[2]), .accumulate_enable(acc[2]),
    .bias_sel(bias[2]), .fc_output_ready(fcr[2]),
    .enable_write_next(ewn[2])
  );

  assign etp[7:3]  = '0;
  assign stn[7:3]  = '0;
  assign ifm[7:3]  = '0;
  assign wm[7:3]   = '0;
  assign acc[7:3]  = '0;
  assign bias[7:3] = '0;
  assign fcr[7:3]  = '0;
  assign ewn[7:3]  = '0;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] sb[$];

  // {etp, stn, ifm_en, wm_en, acc, bias, fcr, ewn, addr[7:0]}
  function automatic logic [15:0] obs(input int s);
    logic [7:0] a;
    case (s)
      0:       a = 8'(a0);
      1:       a = 8'(a1);
      default: a = 8'(a2);
    endcase
    return {etp[s], stn[s], ifm[s], wm[s], acc[s],
            bias[s], fcr[s], ewn[s], a};
  endfunction

  function automatic logic [15:0] expv(
    input int k, input int d, input int rel, input int rst_k
  );
    logic en;
    logic [7:0] a;
    if (k <= 0 || k >= rel || (rst_k > 0 && k > rst_k))
      return 16'h8000;
    en = (k >= 1 && k <= d);
    a  = en ? 8'(k - 1) : 8'd0;
    return {1'b0, (k == d + 4), en, en,
            (k >= 2 && k <= d + 1), (k == 2),
            (k == d + 2), (k == d + 3), a};
  endfunction

  task automatic chk(
    input string tag, input logic [15:0] got, input logic [15:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(
    input string name, input int s, input int d,
    input int efn_on, input logic [31:0] smask,
    input int rst_k, input int ncyc, input bit pad
  );
    int rel;
    logic [15:0] e;
    rel = (efn_on + 1 > d + 5) ? efn_on + 1 : d + 5;
    if (pad) begin
      start = 1'b0;
      efn   = 1'b1;
      repeat (12) @(posedge clk);
      #1;
    end
    start = 1'b1;
    efn   = (efn_on <= 0);
    for (int k = 1; k <= ncyc; k++) begin
      sb.push_back(expv(k, d, rel, rst_k));
      @(posedge clk);
      #1;
      start = smask[k];
      efn   = (k >= efn_on);
      reset = (rst_k > 0 && k == rst_k);
      e = sb.pop_front();
      chk($sformatf("%s k=%0d", name, k), obs(s), e);
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    efn   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++)
      chk($sformatf("reset dut%0d", s), obs(s), 16'h8000);
    reset = 1'b0;

    run("d4_basic", 0, 4, 0, 32'h0, 0, 11, 1'b1);
    run("d4_hold", 0, 4, 20, 32'h0, 0, 23, 1'b1);
    run("d4_extra_start", 0, 4, 0, 32'h144, 0, 11, 1'b1);
    run("d4_reset", 0, 4, 0, 32'h0, 3, 15, 1'b1);
    run("d1_basic", 1, 1, 0, 32'h0, 0, 8, 1'b1);
    run("d5_run1", 2, 5, 0, 32'h0, 0, 10, 1'b1);
    run("d5_run2", 2, 5, 0, 32'h0, 0, 12, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
